// File: rtl/score_disp_pkg.sv
// score_disp_pkg: segment codes, digit decoder and converter state type
package score_disp_pkg;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_TAB [0:15] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                            SEG_8, SEG_9, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
                                            SEG_BLANK, SEG_BLANK};
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    return SEG_TAB[bcd];
  endfunction
  function automatic int dec_digits(input int w);
    longint v;
    int n;
    v = (longint'(1) << w) - 1;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/bcd_dd_conv.sv
// bcd_dd_conv: sequential double-dabble binary to BCD converter
module bcd_dd_conv
  import score_disp_pkg::*;
#(
  parameter int SCORE_W = 14,
  parameter int OUT_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      score,
  output logic                    busy,
  output logic                    done,
  output logic [4*OUT_DIGITS-1:0] bcd
);
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCORE_W - 1);
  conv_state_t state, state_n;
  logic [SCORE_W-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [4*OUT_DIGITS-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < OUT_DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    state_n = start ? SHIFT :
              state == SHIFT && cnt == LAST ? COMMIT :
              state == COMMIT ? IDLE : state;
  end
  assign busy = state != IDLE;
  assign done = state == COMMIT && !start;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      bcd <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        sr <= score;
        cnt <= '0;
        bcd <= '0;
      end else if (state == SHIFT) begin
        sr <= sr << 1;
        cnt <= cnt + 1'b1;
        bcd <= {adj[4*OUT_DIGITS-2:0], sr[SCORE_W-1]};
      end
    end
  end
endmodule

// File: rtl/score_seg_scanner.sv
// score_seg_scanner: latched score to BCD, multiplexed 7-segment scan with leading-zero blanking
module score_seg_scanner
  import score_disp_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SCORE_W = 14,
  parameter int SCAN_DIV = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLANK_LEAD = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SCORE_W-1:0]  score,
  input  logic                load,
  output logic                busy,
  output logic                ovf,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] dig_en
);
  localparam int CONV_D = dec_digits(SCORE_W) > N_DIGITS ? dec_digits(SCORE_W) : N_DIGITS;
  localparam int IDX_W = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  logic done;
  logic over;
  logic lead;
  logic [4*CONV_D-1:0] bcd;
  logic [4*N_DIGITS-1:0] disp;
  logic [DIV_W-1:0] div;
  logic [IDX_W-1:0] idx;
  logic [N_DIGITS-1:0] blank;
  logic [N_DIGITS-1:0] onehot;
  logic [6:0] code;
  bcd_dd_conv #(.SCORE_W(SCORE_W), .OUT_DIGITS(CONV_D)) u_conv (
    .clk(clk),
    .reset(reset),
    .start(load),
    .score(score),
    .busy(busy),
    .done(done),
    .bcd(bcd)
  );
  assign over = |(bcd >> 4*N_DIGITS);
  assign onehot = N_DIGITS'(1) << idx;
  always_comb begin
    blank = '0;
    lead = 1'b1;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      lead = lead && disp[4*k +: 4] == 4'd0;
      blank[k] = BLANK_LEAD != 0 && lead;
    end
    code = blank[idx] ? SEG_BLANK : seg_decode(disp[4*idx +: 4]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      disp <= '0;
      ovf <= 1'b0;
      div <= '0;
      idx <= '0;
      seg <= SEG_ACTIVE_LOW != 0 ? SEG_0 : ~SEG_0;
      dig_en <= DIG_ACTIVE_LOW != 0 ? ~N_DIGITS'(1) : N_DIGITS'(1);
    end else begin
      if (done) begin
        ovf <= over;
        disp <= over ? {N_DIGITS{4'd9}} : bcd[4*N_DIGITS-1:0];
      end
      div <= div == DIV_LAST ? '0 : div + 1'b1;
      if (div == DIV_LAST)
        idx <= idx == IDX_LAST ? '0 : idx + 1'b1;
      seg <= SEG_ACTIVE_LOW != 0 ? code : ~code;
      dig_en <= DIG_ACTIVE_LOW != 0 ? ~onehot : onehot;
    end
  end
endmodule

// File: tb/tb_score_seg_scanner.sv
// tb_score_seg_scanner: directed self-checking bench for score_seg_scanner
module tb_score_seg_scanner;
  localparam logic [6:0] S [0:10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
                                      7'b1111111};
  localparam int BL = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic load_nb = 1'b0;
  logic [13:0] score = '0;
  logic busy, ovf, busy_nb, ovf_nb;
  logic [6:0] seg, seg_nb;
  logic [3:0] dig_en, dig_nb;
  int checks = 0;
  int errors = 0;
  int n42 = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (seg === S[4] || seg === S[2]) n42++;
  score_seg_scanner #(.SCAN_DIV(4)) u_dut (
    .clk(clk), .reset(reset), .score(score), .load(load),
    .busy(busy), .ovf(ovf), .seg(seg), .dig_en(dig_en)
  );
  score_seg_scanner #(.SCAN_DIV(4), .BLANK_LEAD(0)) u_nb (
    .clk(clk), .reset(reset), .score(score), .load(load_nb),
    .busy(busy_nb), .ovf(ovf_nb), .seg(seg_nb), .dig_en(dig_nb)
  );
  task automatic wait_digit(input bit nb, input int k, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if ((nb ? dig_nb : dig_en) == want) ok = 1'b1;
      else @(negedge clk);
    end
  endtask
  task automatic read_digits(input bit nb, output logic [3:0][6:0] got);
    bit ok;
    for (int k = 0; k < 4; k++) begin
      wait_digit(nb, k, ok);
      got[k] = ok ? (nb ? seg_nb : seg) : 7'bx;
    end
  endtask
  task automatic pulse(input bit nb, input logic [13:0] v);
    @(negedge clk);
    score = v;
    if (nb) load_nb = 1'b1;
    else load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    load_nb = 1'b0;
  endtask
  task automatic busy_len(input bit nb, output int n);
    n = 0;
    while ((nb ? busy_nb : busy) && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    logic [6:0] s0;
    int k, run;
    repeat (3) @(negedge clk);
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    if (dig_en !== 4'b1110) begin errors++; $display("FAIL reset_dig got %b want 1110", dig_en); end
    if (seg !== S[0]) begin errors++; $display("FAIL reset_seg got %b want %b", seg, S[0]); end
    reset = 1'b0;
    for (int i = 0; i < 20 && dig_en !== 4'b1101; i++) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      k = (j + 1) % 4;
      s0 = seg;
      run = 0;
      while (dig_en == ~(4'b0001 << k) && run < 20) begin
        run++;
        @(negedge clk);
      end
      checks += 2;
      if (run != 4) begin errors++; $display("FAIL scan_period digit%0d got %0d want 4", k, run); end
      if (s0 !== S[k == 0 ? 0 : BL]) begin errors++; $display("FAIL idle_seg digit%0d got %b want %b", k, s0, S[k == 0 ? 0 : BL]); end
    end
  endtask
  task automatic test_load_1234;
    int n;
    int e [4] = '{4, 3, 2, 1};
    logic [3:0][6:0] got;
    pulse(0, 14'd1234);
    busy_len(0, n);
    checks++;
    if (n != 15) begin errors++; $display("FAIL busy_len got %0d want 15", n); end
    @(negedge clk);
    read_digits(0, got);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== S[e[k]]) begin errors++; $display("FAIL load1234 digit%0d got %b want %b", k, got[k], S[e[k]]); end
    end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL load1234_ovf got %b want 0", ovf); end
  endtask
  task automatic test_overflow;
    int n;
    logic [3:0][6:0] got;
    pulse(0, 14'd9999);
    busy_len(0, n);
    @(negedge clk);
    read_digits(0, got);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== S[9]) begin errors++; $display("FAIL load9999 digit%0d got %b want %b", k, got[k], S[9]); end
    end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL load9999_ovf got %b want 0", ovf); end
    pulse(0, 14'd10000);
    repeat (14) @(negedge clk);
    checks += 2;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf); end
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_commit got %b want 1", busy); end
    @(negedge clk);
    checks += 2;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_latency got %b want 1", ovf); end
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_drop got %b want 0", busy); end
    @(negedge clk);
    read_digits(0, got);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== S[9]) begin errors++; $display("FAIL sat digit%0d got %b want %b", k, got[k], S[9]); end
    end
    pulse(0, 14'd0);
    busy_len(0, n);
    @(negedge clk);
    read_digits(0, got);
    checks += 3;
    if (ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf got %b want 0", ovf); end
    if (got[0] !== S[0]) begin errors++; $display("FAIL zero_d0 got %b want %b", got[0], S[0]); end
    if (got[3] !== S[BL]) begin errors++; $display("FAIL zero_d3 got %b want %b", got[3], S[BL]); end
  endtask
  task automatic test_back_to_back;
    int n, n42_0, gaps;
    logic [3:0][6:0] got;
    n42_0 = n42;
    gaps = 0;
    pulse(0, 14'd42);
    if (busy !== 1'b1) gaps++;
    @(negedge clk);
    if (busy !== 1'b1) gaps++;
    score = 14'd7;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    busy_len(0, n);
    checks += 2;
    if (gaps != 0) begin errors++; $display("FAIL b2b_busy_gap got %0d want 0", gaps); end
    if (n != 15) begin errors++; $display("FAIL b2b_busy_len got %0d want 15", n); end
    @(negedge clk);
    read_digits(0, got);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== S[k == 0 ? 7 : BL]) begin errors++; $display("FAIL b2b digit%0d got %b want %b", k, got[k], S[k == 0 ? 7 : BL]); end
    end
    checks++;
    if (n42 != n42_0) begin errors++; $display("FAIL b2b_no42 got %0d want %0d", n42, n42_0); end
  endtask
  task automatic test_reset_abort;
    int nb;
    logic [3:0][6:0] got;
    pulse(0, 14'd5678);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    if (ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b want 0", ovf); end
    nb = 0;
    repeat (30) begin
      if (busy !== 1'b0) nb++;
      @(negedge clk);
    end
    checks++;
    if (nb != 0) begin errors++; $display("FAIL abort_late_busy got %0d want 0", nb); end
    read_digits(0, got);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== S[k == 0 ? 0 : BL]) begin errors++; $display("FAIL abort digit%0d got %b want %b", k, got[k], S[k == 0 ? 0 : BL]); end
    end
  endtask
  task automatic test_no_blank;
    int n, bad, k;
    int e [4] = '{5, 0, 3, 0};
    logic [3:0][6:0] got;
    pulse(1, 14'd305);
    busy_len(1, n);
    checks++;
    if (n != 15) begin errors++; $display("FAIL nb_busy_len got %0d want 15", n); end
    @(negedge clk);
    read_digits(1, got);
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (got[j] !== S[e[j]]) begin errors++; $display("FAIL noblank digit%0d got %b want %b", j, got[j], S[e[j]]); end
    end
    pulse(1, 14'd305);
    bad = 0;
    repeat (40) begin
      k = -1;
      for (int j = 0; j < 4; j++) if (dig_nb === ~(4'b0001 << j)) k = j;
      if (k < 0 || seg_nb !== S[e[k < 0 ? 0 : k]]) bad++;
      @(negedge clk);
    end
    checks += 2;
    if (bad != 0) begin errors++; $display("FAIL same_score_glitch got %0d want 0", bad); end
    if (ovf_nb !== 1'b0) begin errors++; $display("FAIL nb_ovf got %b want 0", ovf_nb); end
  endtask
  initial begin
    test_reset;
    test_load_1234;
    test_overflow;
    test_back_to_back;
    test_reset_abort;
    test_no_blank;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
